// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty,
// standard or first-word-fall-through read, and sticky overflow/underflow flags.
module sync_fifo_flags #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           data_out,
    output logic                       valid,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;
    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
    localparam ptr_t AF_P    = ptr_t'(AF_THRESH);
    localparam ptr_t AE_P    = ptr_t'(AE_THRESH);

    // Handshake: a write is taken on a rising edge when wr_en && !full, a read
    // when rd_en && !empty; both use pre-edge state, rejected requests are no-ops.
    ptr_t             wr_ptr;
    ptr_t             rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_accept;
    logic             rd_accept;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    assign count        = wr_ptr - rd_ptr;
    assign empty        = (count == '0);
    assign full         = (count == DEPTH_P);
    assign almost_empty = (count <= AE_P);
    assign almost_full  = (count >= AF_P);
    assign wr_accept    = wr_en && !full;
    assign rd_accept    = rd_en && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
            if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) mem[wr_ptr[AW-1:0]] <= data_in;
    end

    // A new error event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full)  overflow <= 1'b1;
            else if (clr_err)   overflow <= 1'b0;
            if (rd_en && empty) underflow <= 1'b1;
            else if (clr_err)   underflow <= 1'b0;
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [WIDTH-1:0] data_r;
            logic             valid_r;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_r  <= '0;
                    valid_r <= 1'b0;
                end else begin
                    valid_r <= rd_accept;
                    if (rd_accept) data_r <= mem[rd_ptr[AW-1:0]];
                end
            end
            assign data_out = data_r;
            assign valid    = valid_r;
        end else begin : g_fwft
            // Head word shown directly; forced to zero while empty so reset reads 0.
            assign data_out = empty ? '0 : mem[rd_ptr[AW-1:0]];
            assign valid    = !empty;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: standard-read instance checked through a data
// scoreboard, plus a first-word-fall-through instance checked inline.
module tb_sync_fifo_flags;

    localparam int W = 8;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;

    logic         wr_en = 0, rd_en = 0, clr_err = 0;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] data_out;
    logic         valid, empty, full, almost_empty, almost_full, overflow, underflow;
    logic [4:0]   count;

    logic         f_wr_en = 0, f_rd_en = 0, f_clr_err = 0;
    logic [W-1:0] f_data_in = '0;
    logic [W-1:0] f_data_out;
    logic         f_valid, f_empty, f_full, f_almost_empty, f_almost_full, f_overflow, f_underflow;
    logic [4:0]   f_count;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] model_q[$];
    logic [W-1:0] exp_q[$];
    bit           rd_pend = 0;
    bit           m_ovf = 0, m_udf = 0;

    sync_fifo_flags #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(data_out), .valid(valid), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    sync_fifo_flags #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_fwft (
        .clk(clk), .reset(reset), .wr_en(f_wr_en), .data_in(f_data_in), .rd_en(f_rd_en),
        .data_out(f_data_out), .valid(f_valid), .empty(f_empty), .full(f_full),
        .almost_empty(f_almost_empty), .almost_full(f_almost_full), .count(f_count),
        .overflow(f_overflow), .underflow(f_underflow), .clr_err(f_clr_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard: valid must follow an accepted read by one cycle with the expected word
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            total++;
            if (valid !== rd_pend) begin
                bad++;
                $display("FAIL sb_valid: got %b want %b at %0t", valid, rd_pend, $time);
            end
            if (rd_pend) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_empty_queue: got data %h with no expected word", data_out);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    if (data_out !== e) begin
                        bad++;
                        $display("FAIL sb_data: got %h want %h at %0t", data_out, e, $time);
                    end
                end
            end
        end
    end

    // driver: one clock of stimulus on the standard instance, updating the model
    task automatic cyc(input bit w, input logic [W-1:0] d, input bit r, input bit c);
        int  sz;
        bit  aw, ar;
        sz = model_q.size();
        aw = w && (sz < D);
        ar = r && (sz != 0);
        wr_en = w; data_in = d; rd_en = r; clr_err = c;
        if (ar) exp_q.push_back(model_q.pop_front());
        if (aw) model_q.push_back(d);
        if (w && sz == D) m_ovf = 1;
        else if (c)       m_ovf = 0;
        if (r && sz == 0) m_udf = 1;
        else if (c)       m_udf = 0;
        rd_pend = ar;
        @(posedge clk);
        #2;
        wr_en = 0; rd_en = 0; clr_err = 0; rd_pend = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (count !== 5'd0)       begin bad++; $display("FAIL rst_count: got %0d want 0", count); end
        total++; if (empty !== 1'b1)       begin bad++; $display("FAIL rst_empty: got %b want 1", empty); end
        total++; if (full !== 1'b0)        begin bad++; $display("FAIL rst_full: got %b want 0", full); end
        total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL rst_ae: got %b want 1", almost_empty); end
        total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL rst_af: got %b want 0", almost_full); end
        total++; if (data_out !== 8'h00)   begin bad++; $display("FAIL rst_data: got %h want 00", data_out); end
        total++; if (valid !== 1'b0)       begin bad++; $display("FAIL rst_valid: got %b want 0", valid); end
        total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
            bad++; $display("FAIL rst_err: got ovf=%b udf=%b want 0 0", overflow, underflow);
        end
        total++; if (f_valid !== 1'b0 || f_data_out !== 8'h00) begin
            bad++; $display("FAIL rst_fwft: got valid=%b data=%h want 0 00", f_valid, f_data_out);
        end
        @(negedge clk);
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_fill();
        for (int i = 0; i < D; i++) begin
            cyc(1, W'(i), 0, 0);
            total++;
            if (count !== 5'(model_q.size()) || almost_full !== (model_q.size() >= D - 2)) begin
                bad++;
                $display("FAIL fill_count: got count=%0d af=%b want count=%0d af=%b",
                         count, almost_full, model_q.size(), model_q.size() >= D - 2);
            end
        end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full: got %b want 1", full); end
        cyc(1, 8'hEE, 0, 0);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fill_ovf: got %b want 1", overflow); end
        total++; if (count !== 5'd16)   begin bad++; $display("FAIL fill_ovf_count: got %0d want 16", count); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < D; i++) cyc(0, '0, 1, 0);
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty: got %b want 1", empty); end
        cyc(0, '0, 1, 0);
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL drain_udf: got %b want 1", underflow); end
        total++; if (overflow !== 1'b1)  begin bad++; $display("FAIL drain_ovf_sticky: got %b want 1", overflow); end
        cyc(0, '0, 0, 1);
        total++; if (overflow !== m_ovf || underflow !== m_udf) begin
            bad++; $display("FAIL clr_err: got ovf=%b udf=%b want %b %b", overflow, underflow, m_ovf, m_udf);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) cyc(1, W'($urandom_range(0, 255)), 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(1, W'(8'h80 + i), 1, 0);
            total++;
            if (count !== 5'd5) begin bad++; $display("FAIL b2b_count: got %0d want 5", count); end
        end
        while (model_q.size() < D) cyc(1, W'($urandom_range(0, 255)), 0, 0);
        cyc(1, 8'h77, 1, 0);
        total++; if (count !== 5'd15) begin bad++; $display("FAIL full_rw_count: got %0d want 15", count); end
        while (model_q.size() > 0) cyc(0, '0, 1, 0);
        cyc(0, '0, 0, 1);
    endtask

    task automatic test_wrap();
        logic [W-1:0] pat;
        pat = 8'h40;
        for (int i = 0; i < 40; i++) begin
            cyc(1, pat, (i > 0) && ($urandom_range(0, 3) != 0), 0);
            pat++;
            total++;
            if (count !== 5'(model_q.size()) || empty !== (model_q.size() == 0) ||
                full !== (model_q.size() == D) || almost_empty !== (model_q.size() <= 2)) begin
                bad++;
                $display("FAIL wrap_flags: got count=%0d e=%b f=%b ae=%b want count=%0d",
                         count, empty, full, almost_empty, model_q.size());
            end
        end
        while (model_q.size() > 0) cyc(0, '0, 1, 0);
        total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
            bad++; $display("FAIL wrap_err: got ovf=%b udf=%b want 0 0", overflow, underflow);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 9; i++) cyc(1, W'(8'h90 + i), 0, 0);
        cyc(1, 8'hA0, 1, 0);
        #1 reset = 1;
        #1;
        total++; if (count !== 5'd0 || empty !== 1'b1 || valid !== 1'b0 || data_out !== 8'h00) begin
            bad++; $display("FAIL mid_reset: got count=%0d e=%b v=%b d=%h want 0 1 0 00",
                            count, empty, valid, data_out);
        end
        model_q.delete();
        exp_q.delete();
        m_ovf = 0; m_udf = 0;
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        cyc(1, 8'h3C, 0, 0);
        total++; if (count !== 5'd1) begin bad++; $display("FAIL post_rst_count: got %0d want 1", count); end
        cyc(0, '0, 1, 0);
        cyc(0, '0, 0, 0);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL post_rst_left: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_fwft();
        f_wr_en = 1; f_data_in = 8'hA5;
        @(posedge clk); #1;
        f_wr_en = 0;
        total++; if (f_valid !== 1'b1 || f_data_out !== 8'hA5) begin
            bad++; $display("FAIL fwft_show: got v=%b d=%h want 1 a5", f_valid, f_data_out);
        end
        f_wr_en = 1; f_data_in = 8'h5A;
        @(posedge clk); #1;
        f_wr_en = 0; f_rd_en = 1;
        total++; if (f_data_out !== 8'hA5 || f_count !== 5'd2) begin
            bad++; $display("FAIL fwft_head: got d=%h c=%0d want a5 2", f_data_out, f_count);
        end
        @(posedge clk); #1;
        f_rd_en = 0;
        total++; if (f_data_out !== 8'h5A || f_valid !== 1'b1) begin
            bad++; $display("FAIL fwft_next: got d=%h v=%b want 5a 1", f_data_out, f_valid);
        end
        f_rd_en = 1;
        @(posedge clk); #1;
        f_rd_en = 0;
        total++; if (f_empty !== 1'b1 || f_valid !== 1'b0) begin
            bad++; $display("FAIL fwft_pop: got e=%b v=%b want 1 0", f_empty, f_valid);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_wrap();
        test_fwft();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
